// File: rtl/knn_result_reader_pkg.sv
// Shared types and constants for the KNN result reader: FSM states, request
// kinds, address-map anchors and the empty-slot marker word.
package knn_result_reader_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FETCH = 3'd1,
    ST_CLR   = 3'd2,
    ST_SCAN  = 3'd3,
    ST_PICK  = 3'd4,
    ST_RESP  = 3'd5
  } state_e;

  typedef enum logic [1:0] {
    REQ_ENTRY    = 2'd0,
    REQ_STATUS   = 2'd1,
    REQ_UNMAPPED = 2'd2
  } req_kind_e;

  localparam int          ADDR_VOTE       = 0;
  // STATUS lives at word K + ADDR_STATUS_OFS, directly after the entry window.
  localparam int          ADDR_STATUS_OFS = 1;
  localparam logic [31:0] EMPTY_WORD      = 32'h8000_0000;

endpackage

// File: rtl/knn_label_hist.sv
// Per-label occurrence counters used by the majority vote: synchronous clear,
// single-label increment and a combinational read port.
module knn_label_hist #(
  parameter int LABEL_W = 4,
  parameter int CNT_W   = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clr,
  input  logic               inc,
  input  logic [LABEL_W-1:0] inc_label,
  input  logic [LABEL_W-1:0] rd_label,
  output logic [CNT_W-1:0]   rd_count
);

  localparam int NLABELS = 2 ** LABEL_W;

  logic [CNT_W-1:0] cnt_q [NLABELS];

  // NOTE: this array is a bank of flops, not a RAM, so giving every counter the
  // async reset is legal and guarantees a clean histogram after rst.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int l = 0; l < NLABELS; l++) cnt_q[l] <= '0;
    end else if (clr) begin
      for (int l = 0; l < NLABELS; l++) cnt_q[l] <= '0;
    end else if (inc) begin
      cnt_q[inc_label] <= cnt_q[inc_label] + CNT_W'(1);
    end
  end

  assign rd_count = cnt_q[rd_label];

endmodule

// File: rtl/knn_result_reader.sv
// Bus read responder for the KNN accelerator: serves neighbour entries, a status
// word, and a majority-vote label computed on demand by scanning the list.
module knn_result_reader
  import knn_result_reader_pkg::*;
#(
  parameter int K       = 4,
  parameter int LABEL_W = 4,
  parameter int DIST_W  = 16,
  parameter int ADDR_W  = 5,
  localparam int CNT_W  = $clog2(K + 1),
  localparam int IDX_W  = (K > 1) ? $clog2(K) : 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               valid,
  input  logic [ADDR_W-1:0]  address,
  input  logic [3:0]         wstrb,
  output logic [31:0]        rdata,
  output logic               ready,
  input  logic [CNT_W-1:0]   nb_count,
  output logic [IDX_W-1:0]   nb_idx,
  input  logic [LABEL_W-1:0] nb_label,
  input  logic [DIST_W-1:0]  nb_dist,
  output logic               busy
);

  state_e             state_q, state_d;
  req_kind_e          kind_q;
  logic [IDX_W-1:0]   idx_q;
  logic [LABEL_W-1:0] lbl_q;
  logic [CNT_W-1:0]   max_cnt_q;
  logic [LABEL_W-1:0] max_lbl_q;
  logic [CNT_W-1:0]   hist_cnt;
  logic [31:0]        resp_d;

  logic               accept, is_vote, is_entry, is_status;
  logic [CNT_W-1:0]   cnt_c;
  logic               cand_gt;
  logic [CNT_W-1:0]   win_cnt;
  logic [LABEL_W-1:0] win_lbl;

  assign accept    = (state_q == ST_IDLE) && valid && (wstrb == 4'b0000);
  assign is_vote   = (address == ADDR_W'(ADDR_VOTE));
  assign is_entry  = (address >= ADDR_W'(1)) && (address <= ADDR_W'(K));
  assign is_status = (address == ADDR_W'(K + ADDR_STATUS_OFS));

  // An out-of-range count from the control unit is treated as a full list.
  assign cnt_c = (nb_count > CNT_W'(K)) ? CNT_W'(K) : nb_count;

  // Strict compare keeps the first label to reach the maximum, i.e. the lowest.
  assign cand_gt = (hist_cnt > max_cnt_q);
  assign win_cnt = cand_gt ? hist_cnt : max_cnt_q;
  assign win_lbl = cand_gt ? lbl_q    : max_lbl_q;

  assign busy   = (state_q != ST_IDLE);
  assign nb_idx = idx_q;

  knn_label_hist #(
    .LABEL_W (LABEL_W),
    .CNT_W   (CNT_W)
  ) u_hist (
    .clk       (clk),
    .rst       (rst),
    .clr       (state_q == ST_CLR),
    .inc       (state_q == ST_SCAN),
    .inc_label (nb_label),
    .rd_label  (lbl_q),
    .rd_count  (hist_cnt)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // NOTE: every output of this block gets a default first, so no path leaves a
  // signal unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    resp_d  = '0;
    case (state_q)
      ST_IDLE: begin
        if (accept) state_d = is_vote ? ST_CLR : ST_FETCH;
      end
      ST_FETCH: begin
        state_d = ST_RESP;
        case (kind_q)
          REQ_ENTRY: begin
            if (CNT_W'(idx_q) < cnt_c) begin
              resp_d[LABEL_W-1:0]  = nb_label;
              resp_d[16 +: DIST_W] = nb_dist;
            end else begin
              resp_d = EMPTY_WORD;
            end
          end
          REQ_STATUS: begin
            resp_d[7:0]   = 8'(cnt_c);
            resp_d[31:24] = 8'(K);
          end
          default: resp_d = '0;
        endcase
      end
      ST_CLR: begin
        state_d = (cnt_c == '0) ? ST_RESP : ST_SCAN;
        resp_d  = EMPTY_WORD;
      end
      ST_SCAN: begin
        if (CNT_W'(idx_q) == cnt_c - CNT_W'(1)) state_d = ST_PICK;
      end
      ST_PICK: begin
        if (lbl_q == '1) state_d = ST_RESP;
        resp_d[LABEL_W-1:0] = win_lbl;
        resp_d[23:16]       = 8'(win_cnt);
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdata     <= '0;
      ready     <= 1'b0;
      idx_q     <= '0;
      lbl_q     <= '0;
      max_cnt_q <= '0;
      max_lbl_q <= '0;
      kind_q    <= REQ_UNMAPPED;
    end else begin
      ready <= (state_d == ST_RESP);
      if (state_d == ST_RESP) rdata <= resp_d;

      case (state_q)
        ST_IDLE: begin
          if (accept) begin
            idx_q  <= is_entry ? IDX_W'(address - ADDR_W'(1)) : '0;
            kind_q <= is_entry ? REQ_ENTRY : (is_status ? REQ_STATUS : REQ_UNMAPPED);
          end
        end
        ST_CLR: begin
          lbl_q     <= '0;
          max_cnt_q <= '0;
          max_lbl_q <= '0;
        end
        ST_SCAN: idx_q <= idx_q + IDX_W'(1);
        ST_PICK: begin
          lbl_q     <= lbl_q + LABEL_W'(1);
          max_cnt_q <= win_cnt;
          max_lbl_q <= win_lbl;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_knn_result_reader.sv
// Directed bench for knn_result_reader (K=4, LABEL_W=4): entry/vote/status reads,
// empty list, count clamping, bus rules and reset abort.
module tb_knn_result_reader;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid;
  logic [4:0]  address;
  logic [3:0]  wstrb;
  logic [31:0] rdata;
  logic        ready;
  logic [2:0]  nb_count;
  logic [1:0]  nb_idx;
  logic [3:0]  nb_label;
  logic [15:0] nb_dist;
  logic        busy;

  logic [3:0]  lbl_mem  [4];
  logic [15:0] dist_mem [4];

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  assign nb_label = lbl_mem[nb_idx];
  assign nb_dist  = dist_mem[nb_idx];

  knn_result_reader dut (
    .clk      (clk),
    .rst      (rst),
    .valid    (valid),
    .address  (address),
    .wstrb    (wstrb),
    .rdata    (rdata),
    .ready    (ready),
    .nb_count (nb_count),
    .nb_idx   (nb_idx),
    .nb_label (nb_label),
    .nb_dist  (nb_dist),
    .busy     (busy)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic set_list(input logic [3:0] l0, l1, l2, l3,
                          input logic [15:0] d0, d1, d2, d3, input logic [2:0] cnt);
    lbl_mem[0] = l0; lbl_mem[1] = l1; lbl_mem[2] = l2; lbl_mem[3] = l3;
    dist_mem[0] = d0; dist_mem[1] = d1; dist_mem[2] = d2; dist_mem[3] = d3;
    nb_count = cnt;
  endtask

  // exp_cycle counts the accepting cycle as cycle 1; ready must appear in that cycle.
  task automatic bus_read(input string tag, input logic [4:0] a,
                          input logic [31:0] exp_data, input int exp_cycle);
    int n;
    bit got;
    n   = 0;
    got = 1'b0;
    @(negedge clk);
    valid = 1'b1; address = a; wstrb = 4'h0;
    while (!got && n < 200) begin
      @(posedge clk); #1;
      n++;
      if (n == 1) check({tag, " busy"}, 32'(busy), 32'd1);
      if (ready) got = 1'b1;
    end
    valid = 1'b0;
    check({tag, " ready"}, 32'(got), 32'd1);
    check({tag, " cycle"}, 32'(n + 1), 32'(exp_cycle));
    check({tag, " data"}, rdata, exp_data);
    @(posedge clk); #1;
    check({tag, " pulse"}, 32'(ready), 32'd0);
  endtask

  initial begin
    int n_ready;
    int n_busy;
    rst = 1'b1; valid = 1'b0; address = '0; wstrb = '0;
    set_list(4'd3, 4'd1, 4'd3, 4'd2, 16'd5, 16'd9, 16'd12, 16'd40, 3'd4);
    repeat (3) @(posedge clk);
    #1;
    check("reset rdata", rdata, 32'h0);
    check("reset ready", 32'(ready), 32'd0);
    check("reset busy", 32'(busy), 32'd0);
    check("reset nb_idx", 32'(nb_idx), 32'd0);
    @(negedge clk); rst = 1'b0;

    // Entry reads and majority vote on {3,1,3,2}
    bus_read("entry2", 5'd2, 32'h0009_0001, 3);
    bus_read("entry4", 5'd4, 32'h0028_0002, 3);
    bus_read("vote", 5'd0, 32'h0002_0003, 23);
    bus_read("status4", 5'd5, 32'h0400_0004, 3);

    // Tie between labels 2 and 5 resolves to 2
    set_list(4'd2, 4'd5, 4'd5, 4'd2, 16'd1, 16'd2, 16'd3, 16'd4, 3'd4);
    bus_read("vote_tie", 5'd0, 32'h0002_0002, 23);

    // Partially filled list: slot 3 is empty
    set_list(4'd3, 4'd1, 4'd3, 4'd2, 16'd5, 16'd9, 16'd12, 16'd40, 3'd3);
    bus_read("entry_past", 5'd4, 32'h8000_0000, 3);
    bus_read("vote3", 5'd0, 32'h0002_0003, 22);

    // Count above K is clamped
    nb_count = 3'd7;
    bus_read("status_clamp", 5'd5, 32'h0400_0004, 3);
    bus_read("vote_clamp", 5'd0, 32'h0002_0003, 23);

    // Empty list
    nb_count = 3'd0;
    bus_read("vote_empty", 5'd0, 32'h8000_0000, 3);
    bus_read("entry_empty", 5'd1, 32'h8000_0000, 3);
    bus_read("status_empty", 5'd5, 32'h0400_0000, 3);

    // Unmapped address answers zero
    nb_count = 3'd4;
    bus_read("entry1_pre", 5'd1, 32'h0005_0003, 3);
    bus_read("unmapped", 5'd20, 32'h0000_0000, 3);

    // Writes are ignored
    n_ready = 0; n_busy = 0;
    @(negedge clk);
    valid = 1'b1; address = 5'd0; wstrb = 4'hF;
    for (int i = 0; i < 30; i++) begin
      @(posedge clk); #1;
      if (ready) n_ready++;
      if (busy) n_busy++;
    end
    valid = 1'b0; wstrb = 4'h0;
    check("write ready count", 32'(n_ready), 32'd0);
    check("write busy count", 32'(n_busy), 32'd0);

    // Held valid: one ready per accept, re-accept only after returning to IDLE
    n_ready = 0;
    @(negedge clk);
    valid = 1'b1; address = 5'd2; wstrb = 4'h0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (ready) n_ready++;
    end
    valid = 1'b0;
    check("held ready count", 32'(n_ready), 32'd3);
    repeat (4) @(posedge clk);
    #1;
    check("held idle", 32'(busy), 32'd0);

    // Reset during SCAN aborts with no response
    @(negedge clk);
    valid = 1'b1; address = 5'd0; wstrb = 4'h0;
    repeat (3) @(posedge clk);
    #1;
    check("abort in progress", 32'(busy), 32'd1);
    rst = 1'b1;
    #1;
    check("abort ready", 32'(ready), 32'd0);
    @(posedge clk); #1;
    check("abort busy", 32'(busy), 32'd0);
    check("abort ready edge", 32'(ready), 32'd0);
    valid = 1'b0;
    @(negedge clk); rst = 1'b0;
    bus_read("vote_after_rst", 5'd0, 32'h0002_0003, 23);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
